// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: redirect/trap/RAS controls in, fetch PC out.
interface pc_gen_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic            stall;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            call_push;
  logic [XLEN-1:0] push_addr;
  logic            ret_pred;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic [CNT_W-1:0] ras_count;

  modport master (
    output stall, trap_valid, trap_vector, redirect_valid, redirect_target,
           call_push, push_addr, ret_pred,
    input  pc_out, pc_valid, ras_count
  );

  modport slave (
    input  stall, trap_valid, trap_vector, redirect_valid, redirect_target,
           call_push, push_addr, ret_pred,
    output pc_out, pc_valid, ras_count
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > stall > redirect > RAS return > sequential.
// Define PC_GEN_RAS_EN to build in the return-address stack.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_2000),
  parameter int unsigned     INST_BYTES   = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input logic    clk,
  input logic    reset,
  pc_gen_if.slave bus
);
  localparam int unsigned     PTR_W      = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W      = PTR_W + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;

`ifdef PC_GEN_RAS_EN
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ras_free, ras_push, ras_we;
  logic [PTR_W-1:0] ras_wptr;

  assign ras_free = ~bus.trap_valid & ~bus.stall & ~bus.redirect_valid;
  assign ras_pop  = ras_free & bus.ret_pred & (cnt_q != '0);
  assign ras_push = ras_free & bus.call_push;
  assign ras_top  = ras_q[top_q];

  always_comb begin
    top_d    = top_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_wptr = top_q;
    if (ras_pop && ras_push) begin
      // Return and call together: consume the old top and replace it in place.
      ras_we = 1'b1;
    end else if (ras_pop) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end else if (ras_push) begin
      ras_we   = 1'b1;
      ras_wptr = top_q + 1'b1;
      top_d    = top_q + 1'b1;
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents need no reset; only pointer and count are architectural.
  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_wptr] <= bus.push_addr;
  end

  assign bus.ras_count = cnt_q;
`else
  logic unused_ras;
  assign unused_ras    = ^{bus.call_push, bus.push_addr, bus.ret_pred};
  assign ras_pop       = 1'b0;
  assign ras_top       = '0;
  assign bus.ras_count = '0;
`endif

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    if (bus.trap_valid) begin
      pc_d    = bus.trap_vector & ALIGN_MASK;
      valid_d = 1'b0;
    end else if (bus.stall) begin
      pc_d    = pc_q;
    end else if (bus.redirect_valid) begin
      pc_d    = bus.redirect_target & ALIGN_MASK;
      valid_d = 1'b0;
    end else if (ras_pop) begin
      pc_d    = ras_top & ALIGN_MASK;
      valid_d = 1'b1;
    end else begin
      pc_d    = pc_q + XLEN'(INST_BYTES);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pc_out   = pc_q;
  assign bus.pc_valid = valid_q;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed literal cases plus random traffic against a queue-based model.
module tb_pc_gen;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned RAS_DEPTH  = 4;
  localparam logic [31:0] RV         = 32'h0000_2000;
  localparam logic [31:0] MASK       = ~32'(INST_BYTES - 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ras [$];

  pc_gen_if #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) bus ();

  pc_gen #(
    .XLEN        (XLEN),
    .RESET_VECTOR(RV),
    .INST_BYTES  (INST_BYTES),
    .RAS_DEPTH   (RAS_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RV;
    m_valid = 1'b0;
    m_ras.delete();
  endtask

  // Next state straight from the priority rules; RAS is a plain bounded stack.
  task automatic model_update();
    logic [31:0] nxt;
    if (reset) begin
      model_reset();
    end else if (bus.trap_valid) begin
      m_pc    = bus.trap_vector & MASK;
      m_valid = 1'b0;
    end else if (bus.stall) begin
      m_pc = m_pc;
    end else if (bus.redirect_valid) begin
      m_pc    = bus.redirect_target & MASK;
      m_valid = 1'b0;
    end else begin
      nxt = m_pc + 32'(INST_BYTES);
`ifdef PC_GEN_RAS_EN
      if (bus.ret_pred && m_ras.size() > 0) begin
        nxt = m_ras[$] & MASK;
        if (bus.call_push) m_ras[m_ras.size()-1] = bus.push_addr;
        else void'(m_ras.pop_back());
      end else if (bus.call_push) begin
        m_ras.push_back(bus.push_addr);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end
`endif
      m_pc    = nxt;
      m_valid = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef PC_GEN_RAS_EN
    return 32'(m_ras.size());
`else
    return 32'd0;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall           = 1'b0;
    bus.trap_valid      = 1'b0;
    bus.trap_vector     = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.call_push       = 1'b0;
    bus.push_addr       = '0;
    bus.ret_pred        = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_out", bus.pc_out, m_pc);
      check("pc_valid", 32'(bus.pc_valid), 32'(m_valid));
      check("ras_count", 32'(bus.ras_count), exp_count());
    end
  end

  initial begin
    clear_inputs();
    #1 reset = 1'b1;
    model_reset();
    cyc();
    cyc();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset then three free cycles.
    check("rst_pc", bus.pc_out, 32'h2000);
    check("rst_valid", 32'(bus.pc_valid), 32'd0);
    check("rst_count", 32'(bus.ras_count), 32'd0);
    cyc(); check("seq1_pc", bus.pc_out, 32'h2004); check("seq1_valid", 32'(bus.pc_valid), 32'd1);
    cyc(); check("seq2_pc", bus.pc_out, 32'h2008);
    cyc(); check("seq3_pc", bus.pc_out, 32'h200C); check("seq3_valid", 32'(bus.pc_valid), 32'd1);

    // Trap beats stall and is aligned.
    bus.stall = 1'b1; bus.trap_valid = 1'b1; bus.trap_vector = 32'h0000_0103;
    cyc(); clear_inputs();
    check("trap_pc", bus.pc_out, 32'h0000_0100);
    check("trap_valid", 32'(bus.pc_valid), 32'd0);

    // Wrap at the top of the address space.
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFE;
    cyc(); clear_inputs();
    check("redir_pc", bus.pc_out, 32'hFFFF_FFFC);
    cyc();
    check("wrap_pc", bus.pc_out, 32'h0000_0000);
    check("wrap_valid", 32'(bus.pc_valid), 32'd1);

    // Stall holds pc_valid low after a redirect.
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h0000_0305;
    cyc(); clear_inputs();
    bus.stall = 1'b1;
    cyc(); clear_inputs();
    check("stall_pc", bus.pc_out, 32'h0000_0304);
    check("stall_valid", 32'(bus.pc_valid), 32'd0);

    // Asynchronous reset pulse between edges.
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_pc", bus.pc_out, 32'h2000);
    check("async_count", 32'(bus.ras_count), 32'd0);
    reset = 1'b0;
    cyc();
    check("post_rst_pc", bus.pc_out, 32'h2004);

`ifdef PC_GEN_RAS_EN
    for (int i = 1; i <= 5; i++) begin
      bus.call_push = 1'b1; bus.push_addr = 32'(i * 16);
      cyc();
    end
    clear_inputs();
    check("ras_full", 32'(bus.ras_count), 32'd4);
    bus.ret_pred = 1'b1;
    cyc(); check("ret1_pc", bus.pc_out, 32'h50); check("ret1_cnt", 32'(bus.ras_count), 32'd3);
    cyc(); check("ret2_pc", bus.pc_out, 32'h40); check("ret2_cnt", 32'(bus.ras_count), 32'd2);
    cyc(); check("ret3_pc", bus.pc_out, 32'h30); check("ret3_cnt", 32'(bus.ras_count), 32'd1);
    cyc(); check("ret4_pc", bus.pc_out, 32'h20); check("ret4_cnt", 32'(bus.ras_count), 32'd0);
    cyc(); check("ret5_pc", bus.pc_out, 32'h24); check("ret5_cnt", 32'(bus.ras_count), 32'd0);
    clear_inputs();

    bus.call_push = 1'b1; bus.push_addr = 32'h100; cyc();
    bus.push_addr = 32'h200; cyc();
    clear_inputs();
    bus.ret_pred = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h800;
    cyc(); clear_inputs();
    check("redir_ret_pc", bus.pc_out, 32'h800);
    check("redir_ret_cnt", 32'(bus.ras_count), 32'd2);

    bus.call_push = 1'b1; bus.push_addr = 32'h300; bus.ret_pred = 1'b1;
    cyc(); clear_inputs();
    check("swap_pc", bus.pc_out, 32'h200);
    check("swap_cnt", 32'(bus.ras_count), 32'd2);
    bus.ret_pred = 1'b1;
    cyc(); clear_inputs();
    check("swap_ret_pc", bus.pc_out, 32'h300);
    check("swap_ret_cnt", 32'(bus.ras_count), 32'd1);
`endif

    // Random traffic, including occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(99) < 1) begin
        reset = 1'b1;
        model_reset();
      end
      bus.trap_valid      = ($urandom_range(99) < 4);
      bus.stall           = ($urandom_range(99) < 15);
      bus.redirect_valid  = ($urandom_range(99) < 8);
      bus.call_push       = ($urandom_range(99) < 35);
      bus.ret_pred        = ($urandom_range(99) < 35);
      bus.trap_vector     = $urandom;
      bus.redirect_target = $urandom;
      bus.push_addr       = $urandom;
      cyc();
    end
    reset = 1'b0;
    clear_inputs();
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL provide parameter XLEN, default 32, PC and target width in bits.
REQ-002 SHALL provide parameter RESET_VECTOR, default 32'h0000_2000, PC value loaded on reset.
REQ-003 SHALL provide parameter INST_BYTES, default 4, sequential increment; power of two, 2..8.
REQ-004 SHALL provide parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, 2..16.
REQ-005 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL provide port stall  input  1  hold PC and RAS state.
REQ-008 SHALL provide port trap_valid  input  1  load trap_vector, highest priority.
REQ-009 SHALL provide port trap_vector  input  XLEN  trap target.
REQ-010 SHALL provide port redirect_valid  input  1  load redirect_target (branch/jump resolved in stage2).
REQ-011 SHALL provide port redirect_target  input  XLEN  redirect target.
REQ-012 SHALL provide port call_push  input  1  push push_addr onto RAS.
REQ-013 SHALL provide port push_addr  input  XLEN  return address to push.
REQ-014 SHALL provide port ret_pred  input  1  fetched instruction is a return; predict from RAS top.
REQ-015 SHALL provide port pc_out  output  XLEN  current fetch PC, registered.
REQ-016 SHALL provide port pc_valid  output  1  low for the first cycle after reset, trap or redirect; high otherwise.
REQ-017 SHALL provide port ras_count  output  log2(RAS_DEPTH)+1  valid RAS entries.

Function
REQ-018 Next-PC priority SHALL be: trap_valid > stall (hold) > redirect_valid > ret_pred with ras_count>0 (RAS top) > pc_out+INST_BYTES.
REQ-019 trap_valid SHALL load trap_vector even while stall is high.
REQ-020 Every loaded target SHALL have its low log2(INST_BYTES) bits forced to zero.
REQ-021 Sequential increment SHALL wrap modulo 2^XLEN; no flag raised.
REQ-022 Every PC update SHALL take effect on the next rising clk edge; one-cycle latency, no combinational input-to-pc_out path.
REQ-023 pc_valid SHALL be registered: 0 in the cycle after reset release or any accepted trap/redirect, else 1; held unchanged during stall.
REQ-024 RAS SHALL be a circular buffer with a top pointer; push writes top+1 and increments ras_count, saturating at RAS_DEPTH.
REQ-025 Push when full SHALL overwrite the oldest entry; ras_count stays RAS_DEPTH.
REQ-026 ret_pred with ras_count>0 SHALL pop: next PC = top entry, top decrements, ras_count decrements.
REQ-027 ret_pred with ras_count=0 SHALL fall back to pc_out+INST_BYTES; RAS unchanged.
REQ-028 Simultaneous call_push and ret_pred SHALL predict the old top and replace it with push_addr; ras_count unchanged.
REQ-029 stall, trap_valid or redirect_valid high SHALL suppress all RAS push/pop in that cycle.

Reset
REQ-030 Reset SHALL immediately drive pc_out=RESET_VECTOR, pc_valid=0, ras_count=0, top pointer=0, independent of clk.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL override all inputs; RAS entry contents are don't-care after reset.
REQ-032 The first edge after reset release with no stall/trap/redirect SHALL produce pc_out=RESET_VECTOR+INST_BYTES, pc_valid=1.

Configuration
REQ-033 Macro PC_GEN_RAS_EN defined SHALL compile in the RAS and REQ-024..REQ-029.
REQ-034 Macro PC_GEN_RAS_EN undefined SHALL remove all RAS storage; call_push, push_addr and ret_pred ignored; ras_count tied to 0; priority reduces to trap > stall > redirect > sequential.

Verification
REQ-035 Reset then 3 free cycles -> pc_out 0x2000, 0x2004, 0x2008, 0x200C; pc_valid 0,1,1,1.
REQ-036 stall=1 and trap_valid=1, trap_vector=0x0000_0103 in the same cycle -> pc_out=0x0000_0100 next cycle, pc_valid=0.
REQ-037 pc_out=0xFFFF_FFFC, no inputs -> pc_out=0x0000_0000 next cycle.
REQ-038 (RAS_EN, depth 4) push 0x10,0x20,0x30,0x40,0x50, then 5 ret_pred -> predictions 0x50,0x40,0x30,0x20, then sequential; ras_count 4,3,2,1,0,0.
REQ-039 (RAS_EN) ras_count=2, ret_pred=1 with redirect_valid=1, target 0x800 -> pc_out=0x800, ras_count stays 2.
REQ-040 Async reset pulse mid-cycle with no clk edge -> pc_out=0x2000, ras_count=0 immediately.
